port_io_router: RTL and testbench
=================================

PORT_IO_ROUTER -- requirements
Module: port_io_router

Interface
REQ-001 Parameter N_CH, default 4: number of data channels; legal range 1..4.
REQ-002 Parameter BASE_ID, default 8'h05: port ID of channel 0.
REQ-003 Parameter DW, default 8: channel data width; fixed at 8.
REQ-004 clk  in  1  single system clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 port_id  in  8  controller port address.
REQ-007 write_strobe  in  1  controller write qualifier, 1-cycle pulse.
REQ-008 read_strobe  in  1  controller read qualifier, 1-cycle pulse.
REQ-009 out_port  in  8  controller write data.
REQ-010 ch_in_data  in  N_CH*8  peripheral input data; channel k occupies bits [8k+7:8k].
REQ-011 ch_in_valid  in  N_CH  per-channel 1-cycle capture strobe.
REQ-012 in_port  out  8  registered read data to the controller.
REQ-013 data_select  out  3  registered decode result: channel index, N_CH = status, 7 = no hit.
REQ-014 ch_out_data  out  N_CH*8  per-channel held write data.
REQ-015 ch_wr_pulse  out  N_CH  1-cycle pulse per channel write.
REQ-016 ch_rd_ack  out  N_CH  1-cycle pulse per channel read.

Function
REQ-017 Decode: port_id in [BASE_ID, BASE_ID+N_CH-1] hits channel port_id-BASE_ID; port_id == BASE_ID+N_CH hits the status port; any other value is a miss; ID arithmetic is 8-bit with no wrap (BASE_ID+N_CH > 8'hFF is illegal).
REQ-018 data_select and in_port register every cycle from the current port_id, 1-cycle latency, independent of the strobes.
REQ-019 in_port on a channel hit = that channel's holding register; on a status hit = {overrun[3:0], valid[3:0]}, with unused bits for k >= N_CH reading 0; on a miss = 8'h00.
REQ-020 Capture: ch_in_valid[k] = 1 loads hold[k] <= ch_in_data[k] and sets valid[k]; if valid[k] was already 1, also sets overrun[k].
REQ-021 Channel read: read_strobe with a hit on channel k clears valid[k] and overrun[k] at the next edge and pulses ch_rd_ack[k] for exactly that next cycle.
REQ-022 Simultaneous capture and read on the same channel: capture wins; valid[k] stays 1, hold[k] updates, overrun[k] is not set, ch_rd_ack[k] still pulses.
REQ-023 Channel write: write_strobe with a hit on channel k loads ch_out_data[k] <= out_port and pulses ch_wr_pulse[k] for the next cycle; other channels hold their values.
REQ-024 Status write: write_strobe with a status hit clears overrun[k] where out_port[4+k] = 1; valid bits are unaffected; overrun set from a same-cycle capture wins over the clear.
REQ-025 Strobes on a miss, and a read of the status port, have no side effects.
REQ-026 write_strobe and read_strobe asserted together: both are acted on independently.
REQ-027 At most one ch_wr_pulse bit and one ch_rd_ack bit are high in any cycle.

Reset
REQ-028 While reset_n = 0 at a clock edge: in_port = 8'h00, data_select = 3'd7, ch_out_data = 0, hold = 0, valid = 0, overrun = 0, ch_wr_pulse = 0, ch_rd_ack = 0.
REQ-029 Reset overrides all strobes in the same cycle, including a capture; a pulse in flight is cut off at the reset edge.

Verification
REQ-030 Reset, then port_id = 8'h06 with write_strobe and out_port = 8'hA5 -> ch_out_data[15:8] = 8'hA5 and ch_wr_pulse = 4'b0010 for one cycle.
REQ-031 ch_in_valid[0] with ch_in_data[7:0] = 8'h3C, then port_id = 8'h09 -> in_port = 8'h01 one cycle later; then read_strobe at 8'h05 -> in_port = 8'h3C, ch_rd_ack = 4'b0001, next status read = 8'h00.
REQ-032 Two captures on channel 2 with no read between them -> status reads 8'h44; write out_port = 8'h40 to 8'h09 -> status reads 8'h04.
REQ-033 Capture and read_strobe on channel 1 in the same cycle -> status bit 1 stays set, bit 5 stays clear, ch_rd_ack = 4'b0010.
REQ-034 port_id = 8'h0A or 8'h04 with both strobes high -> in_port = 8'h00, data_select = 3'd7, and no state change.
REQ-035 reset_n low during a cycle with a capture and a write -> all outputs equal the REQ-028 values on the following cycle.

Source files
------------

// File: rtl/port_io_router_if.sv
// Controller-side port bus: address, strobes, write data and the registered read path.
interface port_io_router_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic [2:0] data_select;

    modport master (
        output port_id, write_strobe, read_strobe, out_port,
        input  in_port, data_select
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port,
        output in_port, data_select
    );
endinterface

// File: rtl/port_io_router.sv
// Port-mapped router: N_CH capture/holding channels plus one status port on a
// controller bus; per-channel state lives in port_io_router_lane.
module port_io_router_lane #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cap,
    input  logic [DW-1:0] cap_data,
    input  logic          rd,
    input  logic          wr,
    input  logic [DW-1:0] wr_data,
    input  logic          clr,
    output logic [DW-1:0] hold,
    output logic          valid,
    output logic          overrun,
    output logic [DW-1:0] out_data,
    output logic          wr_pulse,
    output logic          rd_ack
);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold     <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
            out_data <= '0;
            wr_pulse <= 1'b0;
            rd_ack   <= 1'b0;
        end else begin
            wr_pulse <= wr;
            rd_ack   <= rd;
            if (wr)
                out_data <= wr_data;
            if (cap)
                hold <= cap_data;
            // A capture beats a read; only an unread valid entry becomes an overrun.
            if (cap)
                valid <= 1'b1;
            else if (rd)
                valid <= 1'b0;
            if (cap && valid && !rd)
                overrun <= 1'b1;
            else if (rd || clr)
                overrun <= 1'b0;
        end
    end
endmodule

module port_io_router #(
    parameter int         N_CH    = 4,
    parameter logic [7:0] BASE_ID = 8'h05,
    parameter int         DW      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    port_io_router_if.slave      bus,
    input  logic [N_CH*DW-1:0]   ch_in_data,
    input  logic [N_CH-1:0]      ch_in_valid,
    output logic [N_CH*DW-1:0]   ch_out_data,
    output logic [N_CH-1:0]      ch_wr_pulse,
    output logic [N_CH-1:0]      ch_rd_ack
);
    localparam logic [7:0] ST_ID = BASE_ID + 8'(N_CH);

    logic [N_CH-1:0][DW-1:0] hold;
    logic [N_CH-1:0][DW-1:0] out_q;
    logic [N_CH-1:0]         valid;
    logic [N_CH-1:0]         overrun;
    logic [N_CH-1:0]         ch_hit;
    logic                    st_hit;
    logic [3:0]              vld4;
    logic [3:0]              ovr4;
    logic [2:0]              sel_d;
    logic [7:0]              in_d;

    assign st_hit = (bus.port_id == ST_ID);

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_lane
            assign ch_hit[k] = (bus.port_id == BASE_ID + 8'(k));

            port_io_router_lane #(.DW(DW)) u_lane (
                .clk      (clk),
                .reset_n  (reset_n),
                .cap      (ch_in_valid[k]),
                .cap_data (ch_in_data[DW*k +: DW]),
                .rd       (bus.read_strobe & ch_hit[k]),
                .wr       (bus.write_strobe & ch_hit[k]),
                .wr_data  (bus.out_port),
                .clr      (bus.write_strobe & st_hit & bus.out_port[4+k]),
                .hold     (hold[k]),
                .valid    (valid[k]),
                .overrun  (overrun[k]),
                .out_data (out_q[k]),
                .wr_pulse (ch_wr_pulse[k]),
                .rd_ack   (ch_rd_ack[k])
            );
        end
    endgenerate

    assign ch_out_data = out_q;

    // Status byte is always {overrun[3:0], valid[3:0]}; absent channels read 0.
    always_comb begin
        vld4 = '0;
        ovr4 = '0;
        for (int i = 0; i < N_CH; i++) begin
            vld4[i] = valid[i];
            ovr4[i] = overrun[i];
        end
    end

    always_comb begin
        sel_d = 3'd7;
        in_d  = 8'h00;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_hit[i]) begin
                sel_d = 3'(i);
                in_d  = hold[i];
            end
        end
        if (st_hit) begin
            sel_d = 3'(N_CH);
            in_d  = {ovr4, vld4};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.in_port     <= 8'h00;
            bus.data_select <= 3'd7;
        end else begin
            bus.in_port     <= in_d;
            bus.data_select <= sel_d;
        end
    end
endmodule

// File: tb/tb_port_io_router.sv
// Scoreboard bench for port_io_router: a behavioural model predicts every cycle's
// outputs at drive time; a monitor pops and compares after each rising edge.
module tb_port_io_router;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ch_in_data;
    logic [3:0]  ch_in_valid;
    logic [31:0] ch_out_data;
    logic [3:0]  ch_wr_pulse;
    logic [3:0]  ch_rd_ack;

    int checks = 0;
    int errors = 0;

    port_io_router_if bus();

    port_io_router #(.N_CH(4), .BASE_ID(8'h05), .DW(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .ch_in_data  (ch_in_data),
        .ch_in_valid (ch_in_valid),
        .ch_out_data (ch_out_data),
        .ch_wr_pulse (ch_wr_pulse),
        .ch_rd_ack   (ch_rd_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  in_port;
        logic [2:0]  sel;
        logic [3:0]  wp;
        logic [3:0]  ra;
        logic [31:0] od;
    } exp_t;

    exp_t sb[$];

    // model state
    logic [7:0] m_hold [4];
    logic [7:0] m_out  [4];
    logic [3:0] m_vld;
    logic [3:0] m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("in_port", 32'(bus.in_port), 32'(e.in_port));
            check("data_select", 32'(bus.data_select), 32'(e.sel));
            check("ch_wr_pulse", 32'(ch_wr_pulse), 32'(e.wp));
            check("ch_rd_ack", 32'(ch_rd_ack), 32'(e.ra));
            check("ch_out_data", ch_out_data, e.od);
        end
    end

    task automatic drive(input logic rst, input logic [7:0] pid, input logic ws, input logic rs,
                         input logic [7:0] od, input logic [3:0] civ, input logic [31:0] cid);
        exp_t e;
        int   ch;
        @(negedge clk);
        reset_n          = rst;
        bus.port_id      = pid;
        bus.write_strobe = ws;
        bus.read_strobe  = rs;
        bus.out_port     = od;
        ch_in_valid      = civ;
        ch_in_data       = cid;

        e.wp = '0;
        e.ra = '0;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                m_hold[i] = 8'h00;
                m_out[i]  = 8'h00;
            end
            m_vld     = '0;
            m_ovr     = '0;
            e.in_port = 8'h00;
            e.sel     = 3'd7;
        end else begin
            ch = -1;
            if (pid >= 8'h05 && pid <= 8'h08) ch = int'(pid) - 5;
            if (ch >= 0) begin
                e.sel     = 3'(ch);
                e.in_port = m_hold[ch];
            end else if (pid == 8'h09) begin
                e.sel     = 3'd4;
                e.in_port = {m_ovr, m_vld};
            end else begin
                e.sel     = 3'd7;
                e.in_port = 8'h00;
            end
            for (int i = 0; i < 4; i++) begin
                logic rdk, wrk, clrk;
                rdk = rs && (ch == i);
                wrk = ws && (ch == i);
                clrk = ws && (pid == 8'h09) && od[4+i];
                e.ra[i] = rdk;
                e.wp[i] = wrk;
                if (wrk) m_out[i] = od;
                if (civ[i] && m_vld[i] && !rdk) m_ovr[i] = 1'b1;
                else if (rdk || clrk)           m_ovr[i] = 1'b0;
                if (civ[i]) begin
                    m_hold[i] = cid[8*i +: 8];
                    m_vld[i]  = 1'b1;
                end else if (rdk) begin
                    m_vld[i] = 1'b0;
                end
            end
        end
        e.od = {m_out[3], m_out[2], m_out[1], m_out[0]};
        sb.push_back(e);
    endtask

    task automatic idle(input logic [7:0] pid);
        drive(1'b1, pid, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        settle();
        check("rst_in_port", 32'(bus.in_port), 32'h00);
        check("rst_sel", 32'(bus.data_select), 32'd7);

        // channel 1 write
        drive(1'b1, 8'h06, 1'b1, 1'b0, 8'hA5, 4'h0, 32'h0);
        settle();
        check("wr_od_ch1", 32'(ch_out_data[15:8]), 32'hA5);
        check("wr_pulse_ch1", 32'(ch_wr_pulse), 32'h2);
        idle(8'h00);
        settle();
        check("wr_pulse_end", 32'(ch_wr_pulse), 32'h0);

        // capture ch0, status, read ch0, status again
        drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'h1, 32'h0000_003C);
        idle(8'h09);
        settle();
        check("status_v0", 32'(bus.in_port), 32'h01);
        drive(1'b1, 8'h05, 1'b0, 1'b1, 8'h00, 4'h0, 32'h0);
        settle();
        check("rd_ch0_data", 32'(bus.in_port), 32'h3C);
        check("rd_ch0_ack", 32'(ch_rd_ack), 32'h1);
        idle(8'h09);
        settle();
        check("status_cleared", 32'(bus.in_port), 32'h00);

        // double capture on ch2 -> overrun, then clear via status write
        drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'h4, 32'h0011_0000);
        drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'h4, 32'h0022_0000);
        idle(8'h09);
        settle();
        check("status_ovr2", 32'(bus.in_port), 32'h44);
        drive(1'b1, 8'h09, 1'b1, 1'b0, 8'h40, 4'h0, 32'h0);
        idle(8'h09);
        settle();
        check("status_ovr2_clr", 32'(bus.in_port), 32'h04);

        // capture + read on ch1 in the same cycle
        drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'h2, 32'h0000_5500);
        drive(1'b1, 8'h06, 1'b0, 1'b1, 8'h00, 4'h2, 32'h0000_6600);
        settle();
        check("cap_rd_ack", 32'(ch_rd_ack), 32'h2);
        idle(8'h09);
        settle();
        check("cap_rd_v1", 32'(bus.in_port[1]), 32'h1);
        check("cap_rd_o1", 32'(bus.in_port[5]), 32'h0);

        // misses with both strobes
        drive(1'b1, 8'h0A, 1'b1, 1'b1, 8'hFF, 4'h0, 32'h0);
        settle();
        check("miss_hi_in", 32'(bus.in_port), 32'h00);
        check("miss_hi_sel", 32'(bus.data_select), 32'd7);
        drive(1'b1, 8'h04, 1'b1, 1'b1, 8'hFF, 4'h0, 32'h0);
        idle(8'h09);
        settle();
        check("miss_status", 32'(bus.in_port), 32'h06);

        // reset beats capture and write
        drive(1'b0, 8'h05, 1'b1, 1'b0, 8'h77, 4'hF, 32'hDEAD_BEEF);
        settle();
        check("rst_ovr_od", ch_out_data, 32'h0);
        check("rst_ovr_sel", 32'(bus.data_select), 32'd7);
        idle(8'h09);
        settle();
        check("rst_ovr_status", 32'(bus.in_port), 32'h00);

        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) != 0), 8'($urandom_range(3, 11)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  4'($urandom & $urandom), $urandom);
        end
        repeat (2) @(posedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
